ascon_ctrl: RTL and testbench

ASCON_CTRL -- requirements
Module: ascon_ctrl

---
 rtl/ascon_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_ascon_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_ctrl.sv
// Control FSM for an Ascon AEAD core: sequences the pa/pb permutation rounds,
// key mixing, AD/message absorption, domain separation and tag handoff.
module ascon_ctrl #(
    parameter int unsigned ROUNDS_A = 12,
    parameter int unsigned ROUNDS_B = 6,
    localparam int unsigned RND_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             no_ad_i,
    input  logic             ad_valid_i,
    input  logic             ad_last_i,
    output logic             ad_ready_o,
    input  logic             msg_valid_i,
    input  logic             msg_last_i,
    output logic             msg_ready_o,
    output logic             tag_valid_o,
    input  logic             tag_ready_i,
    output logic             load_o,
    output logic             rnd_en_o,
    output logic             key_xor_o,
    output logic             absorb_o,
    output logic             dom_sep_o,
    output logic             fin_key_o,
    output logic [RND_W-1:0] rnd_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef logic [RND_W-1:0] rnd_t;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        INIT_P   = 4'd1,
        INIT_KEY = 4'd2,
        AD_WAIT  = 4'd3,
        AD_P     = 4'd4,
        DOM_SEP  = 4'd5,
        MSG_WAIT = 4'd6,
        MSG_P    = 4'd7,
        FIN_KEY  = 4'd8,
        FIN_P    = 4'd9,
        TAG      = 4'd10
    } state_e;

    localparam rnd_t LAST_RND = rnd_t'(11);
    localparam rnd_t START_A  = rnd_t'(12 - ROUNDS_A);
    localparam rnd_t START_B  = rnd_t'(12 - ROUNDS_B);

    state_e state_q, state_d;
    rnd_t   cnt_q, cnt_d;
    logic   no_ad_q, no_ad_d;
    logic   ad_last_q, ad_last_d;

    logic   in_p_c, last_rnd_c;
    logic   ad_ready_c, msg_ready_c, tag_valid_c, load_c, rnd_en_c;
    logic   key_xor_c, absorb_c, dom_sep_c, fin_key_c, done_c;
    rnd_t   rnd_c;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            no_ad_q   <= 1'b0;
            ad_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            no_ad_q   <= no_ad_d;
            ad_last_q <= ad_last_d;
        end
    end

    assign in_p_c     = state_q inside {INIT_P, AD_P, MSG_P, FIN_P};
    assign last_rnd_c = (cnt_q == LAST_RND);

    // Strobes react in the same cycle as the handshake so the datapath acts on the accepted block.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        no_ad_d     = no_ad_q;
        ad_last_d   = ad_last_q;
        ad_ready_c  = 1'b0;
        msg_ready_c = 1'b0;
        tag_valid_c = 1'b0;
        load_c      = 1'b0;
        rnd_en_c    = 1'b0;
        key_xor_c   = 1'b0;
        absorb_c    = 1'b0;
        dom_sep_c   = 1'b0;
        fin_key_c   = 1'b0;
        done_c      = 1'b0;
        rnd_c       = '0;

        if (in_p_c) begin
            rnd_en_c = 1'b1;
            rnd_c    = cnt_q;
            cnt_d    = last_rnd_c ? rnd_t'(0) : rnd_t'(cnt_q + rnd_t'(1));
        end

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    load_c  = 1'b1;
                    no_ad_d = no_ad_i;
                    cnt_d   = START_A;
                    state_d = INIT_P;
                end
            end
            INIT_P: begin
                if (last_rnd_c) state_d = INIT_KEY;
            end
            INIT_KEY: begin
                key_xor_c = 1'b1;
                state_d   = no_ad_q ? DOM_SEP : AD_WAIT;
            end
            AD_WAIT: begin
                ad_ready_c = 1'b1;
                if (ad_valid_i) begin
                    absorb_c  = 1'b1;
                    ad_last_d = ad_last_i;
                    cnt_d     = START_B;
                    state_d   = AD_P;
                end
            end
            AD_P: begin
                if (last_rnd_c) state_d = ad_last_q ? DOM_SEP : AD_WAIT;
            end
            DOM_SEP: begin
                dom_sep_c = 1'b1;
                state_d   = MSG_WAIT;
            end
            MSG_WAIT: begin
                msg_ready_c = 1'b1;
                if (msg_valid_i) begin
                    absorb_c = 1'b1;
                    if (msg_last_i) begin
                        state_d = FIN_KEY;
                    end else begin
                        cnt_d   = START_B;
                        state_d = MSG_P;
                    end
                end
            end
            MSG_P: begin
                if (last_rnd_c) state_d = MSG_WAIT;
            end
            FIN_KEY: begin
                fin_key_c = 1'b1;
                cnt_d     = START_A;
                state_d   = FIN_P;
            end
            FIN_P: begin
                if (last_rnd_c) state_d = TAG;
            end
            TAG: begin
                tag_valid_c = 1'b1;
                key_xor_c   = 1'b1;
                if (tag_ready_i) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are forced low for the whole time reset is held, not just after the next edge.
    assign ad_ready_o  = rst_ni & ad_ready_c;
    assign msg_ready_o = rst_ni & msg_ready_c;
    assign tag_valid_o = rst_ni & tag_valid_c;
    assign load_o      = rst_ni & load_c;
    assign rnd_en_o    = rst_ni & rnd_en_c;
    assign key_xor_o   = rst_ni & key_xor_c;
    assign absorb_o    = rst_ni & absorb_c;
    assign dom_sep_o   = rst_ni & dom_sep_c;
    assign fin_key_o   = rst_ni & fin_key_c;
    assign done_o      = rst_ni & done_c;
    assign busy_o      = rst_ni & (state_q != IDLE);
    assign rnd_o       = {RND_W{rst_ni}} & rnd_c;

    a_round_params: assert property (@(posedge clk_i)
        (ROUNDS_A >= 1) && (ROUNDS_A <= 12) && (ROUNDS_B >= 1) && (ROUNDS_B <= 12))
        else $error("ascon_ctrl: ROUNDS_A/ROUNDS_B must lie in 1..12");

    a_strobe_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0({load_o, key_xor_o, absorb_o, dom_sep_o, fin_key_o}))
        else $error("ascon_ctrl: more than one datapath strobe active");

    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= LAST_RND)
        else $error("ascon_ctrl: round counter past last round");

endmodule

// File: tb/tb_ascon_ctrl.sv
// Bench for ascon_ctrl: expected per-cycle traces are built from operation
// descriptions (block counts, wait gaps) and replayed against two parameterisations.
module tb_ascon_ctrl;

    typedef struct packed {
        logic start, no_ad, ad_valid, ad_last, msg_valid, msg_last, tag_ready;
    } in_t;

    typedef struct packed {
        logic ad_ready, msg_ready, tag_valid, load, rnd_en, key_xor;
        logic absorb, dom_sep, fin_key, busy, done;
        logic [3:0] rnd;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    typedef struct {
        int sel, no_ad, n_ad, n_msg, gap, tgap, noisy;
    } scen_t;

    logic clk = 1'b0;
    logic rst_n;
    in_t  drv [2];
    out_t obs [2];
    logic o_ad_ready [2], o_msg_ready [2], o_tag_valid [2], o_load [2], o_rnd_en [2];
    logic o_key_xor [2], o_absorb [2], o_dom_sep [2], o_fin_key [2], o_busy [2], o_done [2];
    logic [3:0] o_rnd [2];

    int   n_checks = 0;
    int   n_fail   = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ascon_ctrl #(
            .ROUNDS_A(g == 0 ? 12 : 8),
            .ROUNDS_B(g == 0 ? 6 : 4)
        ) u_dut (
            .clk_i      (clk),
            .rst_ni     (rst_n),
            .start_i    (drv[g].start),
            .no_ad_i    (drv[g].no_ad),
            .ad_valid_i (drv[g].ad_valid),
            .ad_last_i  (drv[g].ad_last),
            .ad_ready_o (o_ad_ready[g]),
            .msg_valid_i(drv[g].msg_valid),
            .msg_last_i (drv[g].msg_last),
            .msg_ready_o(o_msg_ready[g]),
            .tag_valid_o(o_tag_valid[g]),
            .tag_ready_i(drv[g].tag_ready),
            .load_o     (o_load[g]),
            .rnd_en_o   (o_rnd_en[g]),
            .key_xor_o  (o_key_xor[g]),
            .absorb_o   (o_absorb[g]),
            .dom_sep_o  (o_dom_sep[g]),
            .fin_key_o  (o_fin_key[g]),
            .rnd_o      (o_rnd[g]),
            .busy_o     (o_busy[g]),
            .done_o     (o_done[g])
        );
        assign obs[g] = {o_ad_ready[g], o_msg_ready[g], o_tag_valid[g], o_load[g], o_rnd_en[g],
                         o_key_xor[g], o_absorb[g], o_dom_sep[g], o_fin_key[g], o_busy[g],
                         o_done[g], o_rnd[g]};
    end

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic in_t fill(input int noisy);
        logic [6:0] b;
        in_t r;
        b = noisy != 0 ? 7'($urandom_range(0, 127)) : 7'd0;
        r = b;
        return r;
    endfunction

    function automatic out_t o_busy_exp();
        out_t o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    task automatic push(input in_t i, input out_t o);
        vec_t v;
        v.in  = i;
        v.exp = o;
        vq.push_back(v);
    endtask

    task automatic push_rounds(input int rounds, input int noisy);
        out_t o;
        for (int k = 0; k < rounds; k++) begin
            o        = o_busy_exp();
            o.rnd_en = 1'b1;
            o.rnd    = 4'(12 - rounds + k);
            push(fill(noisy), o);
        end
    endtask

    function automatic int pick_gap(input int gap);
        return gap < 0 ? int'($urandom_range(0, 3)) : gap;
    endfunction

    // Expected trace of one whole operation, derived from the block counts and wait gaps.
    task automatic build_op(input int no_ad, input int n_ad, input int n_msg, input int ra,
                            input int rb, input int gap, input int tgap, input int noisy);
        in_t  i;
        out_t o;
        int   g;
        i = fill(noisy); i.start = 1'b1; i.no_ad = no_ad[0];
        o = '0; o.load = 1'b1;
        push(i, o);
        push_rounds(ra, noisy);
        o = o_busy_exp(); o.key_xor = 1'b1;
        push(fill(noisy), o);
        if (no_ad == 0) begin
            for (int b = 0; b < n_ad; b++) begin
                g = pick_gap(gap);
                for (int k = 0; k < g; k++) begin
                    i = fill(noisy); i.ad_valid = 1'b0;
                    o = o_busy_exp(); o.ad_ready = 1'b1;
                    push(i, o);
                end
                i = fill(noisy); i.ad_valid = 1'b1; i.ad_last = (b == n_ad - 1);
                o = o_busy_exp(); o.ad_ready = 1'b1; o.absorb = 1'b1;
                push(i, o);
                push_rounds(rb, noisy);
            end
        end
        o = o_busy_exp(); o.dom_sep = 1'b1;
        push(fill(noisy), o);
        for (int m = 0; m < n_msg; m++) begin
            g = pick_gap(gap);
            for (int k = 0; k < g; k++) begin
                i = fill(noisy); i.msg_valid = 1'b0;
                o = o_busy_exp(); o.msg_ready = 1'b1;
                push(i, o);
            end
            i = fill(noisy); i.msg_valid = 1'b1; i.msg_last = (m == n_msg - 1);
            o = o_busy_exp(); o.msg_ready = 1'b1; o.absorb = 1'b1;
            push(i, o);
            if (m != n_msg - 1) push_rounds(rb, noisy);
        end
        o = o_busy_exp(); o.fin_key = 1'b1;
        push(fill(noisy), o);
        push_rounds(ra, noisy);
        g = pick_gap(tgap);
        for (int k = 0; k <= g; k++) begin
            i = fill(noisy); i.tag_ready = (k == g);
            o = o_busy_exp(); o.tag_valid = 1'b1; o.key_xor = 1'b1; o.done = (k == g);
            push(i, o);
        end
        i = fill(noisy); i.start = 1'b0;
        push(i, '0);
    endtask

    task automatic apply(input int sel, input int n);
        for (int i = 0; i < n && i < vq.size(); i++) begin
            @(posedge clk);
            #1;
            drv[sel] = vq[i].in;
            @(negedge clk);
            check($sformatf("dut%0d_vec%0d", sel, i), obs[sel], vq[i].exp);
        end
    endtask

    scen_t scen [5];
    out_t  e;

    initial begin
        scen[0] = '{sel: 0, no_ad: 1, n_ad: 0, n_msg: 1, gap: 0,  tgap: 0,  noisy: 0};
        scen[1] = '{sel: 0, no_ad: 0, n_ad: 2, n_msg: 2, gap: 0,  tgap: 0,  noisy: 0};
        scen[2] = '{sel: 0, no_ad: 1, n_ad: 0, n_msg: 2, gap: 5,  tgap: 3,  noisy: 0};
        scen[3] = '{sel: 1, no_ad: 0, n_ad: 1, n_msg: 2, gap: 1,  tgap: 1,  noisy: 0};
        scen[4] = '{sel: 1, no_ad: 1, n_ad: 0, n_msg: 1, gap: -1, tgap: -1, noisy: 1};

        rst_n  = 1'b0;
        drv[0] = '0;
        drv[1] = '0;
        repeat (3) @(negedge clk);
        check("reset_dut0", obs[0], '0);
        check("reset_dut1", obs[1], '0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_dut0", obs[0], '0);

        // Hand-timed no-AD, single-message operation with msg_valid/msg_last held high.
        @(posedge clk);
        #1;
        drv[0] = '0; drv[0].start = 1'b1; drv[0].no_ad = 1'b1;
        drv[0].msg_valid = 1'b1; drv[0].msg_last = 1'b1;
        for (int t = 0; t <= 32; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
                drv[0].start     = 1'b0;
                drv[0].tag_ready = (t == 31);
            end
            @(negedge clk);
            e = '0;
            e.busy = (t > 0 && t < 32);
            if (t == 0) e.load = 1'b1;
            else if (t <= 12) begin e.rnd_en = 1'b1; e.rnd = 4'(t - 1); end
            else if (t == 13) e.key_xor = 1'b1;
            else if (t == 14) e.dom_sep = 1'b1;
            else if (t == 15) begin e.msg_ready = 1'b1; e.absorb = 1'b1; end
            else if (t == 16) e.fin_key = 1'b1;
            else if (t <= 28) begin e.rnd_en = 1'b1; e.rnd = 4'(t - 17); end
            else if (t <= 31) begin e.tag_valid = 1'b1; e.key_xor = 1'b1; e.done = (t == 31); end
            check($sformatf("noad_t%0d", t), obs[0], e);
        end

        for (int s = 0; s < 5; s++) begin
            vq.delete();
            build_op(scen[s].no_ad, scen[s].n_ad, scen[s].n_msg, scen[s].sel != 0 ? 8 : 12,
                     scen[s].sel != 0 ? 4 : 6, scen[s].gap, scen[s].tgap, scen[s].noisy);
            apply(scen[s].sel, vq.size());
        end

        // ad_valid during INIT_P (index 5) and start during MSG_P (index 25) must be ignored.
        vq.delete();
        build_op(0, 1, 2, 12, 6, 0, 0, 0);
        vq[5].in.ad_valid = 1'b1;
        vq[25].in.start   = 1'b1;
        apply(0, vq.size());

        // Reset taken in the middle of AD_P (index 17), with start held during reset.
        vq.delete();
        build_op(0, 2, 1, 12, 6, 0, 0, 0);
        apply(0, 18);
        #2;
        rst_n = 1'b0;
        drv[0].start = 1'b1;
        #1;
        check("rst_mid_async", obs[0], '0);
        @(posedge clk);
        #1;
        check("rst_mid_hold", obs[0], '0);
        @(negedge clk);
        rst_n  = 1'b1;
        drv[0] = '0;
        vq.delete();
        build_op(1, 0, 1, 12, 6, 0, 0, 1);
        apply(0, vq.size());

        for (int r = 0; r < 40; r++) begin
            int sel;
            sel = (r % 4 == 3) ? 1 : 0;
            vq.delete();
            build_op(int'($urandom_range(0, 1)), int'($urandom_range(1, 3)),
                     int'($urandom_range(1, 3)), sel != 0 ? 8 : 12, sel != 0 ? 4 : 6, -1, -1, 1);
            apply(sel, vq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
